// File: rtl/uart_rx_ctrl_pkg.sv
// Shared frame constants and receiver state encoding for the UART receive path.
package uart_rx_ctrl_pkg;

    localparam int unsigned DATA_BITS    = 8;
    localparam int unsigned WDOG_DEFAULT = 128;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StStop,
        StBreak
    } rx_state_e;

endpackage

// File: rtl/uart_baud_strobe.sv
// Programmable sample-strobe generator; one samp_clk pulse every divisor+1 cycles.
module uart_baud_strobe (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [15:0] divisor,
    output logic        samp_clk
);

    logic [15:0] cnt_q;
    logic [15:0] div_q;
    logic        en_q;

    // The extra strobe on the enable 1->0 cycle lets the receiver see its reset.
    always_comb begin
        samp_clk = 1'b0;
        if (reset) begin
            samp_clk = 1'b0;
        end else if (enable) begin
            samp_clk = (cnt_q == div_q);
        end else begin
            samp_clk = en_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || !enable) begin
            cnt_q <= 16'd0;
            div_q <= divisor;
        end else if (samp_clk) begin
            cnt_q <= 16'd0;
            div_q <= divisor;
        end else begin
            cnt_q <= cnt_q + 16'd1;
        end
        en_q <= reset ? 1'b0 : enable;
    end

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: idle 0, start 1, inverted data LSB first, stop 0.
module uart_rx
    import uart_rx_ctrl_pkg::*;
#(
    parameter int unsigned OVERSAMPLE = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 samp_clk,
    input  logic                 in,
    output logic [0:DATA_BITS-1] out,
    output logic                 ready,
    output logic                 err,
    output logic                 busy
);

    localparam logic [OVERSAMPLE-1:0] LAST    = '1;
    localparam logic [OVERSAMPLE-1:0] HALF_M1 = OVERSAMPLE'((1 << OVERSAMPLE) / 2 - 1);
    localparam int unsigned           BW      = $clog2(DATA_BITS);

    rx_state_e              state_q, state_d;
    logic [OVERSAMPLE-1:0]  scnt_q, scnt_d;
    logic [BW-1:0]          bit_q, bit_d;
    logic [0:DATA_BITS-1]   shreg_q, shreg_d;
    logic                   ready_d, err_d;

    always_comb begin
        state_d = state_q;
        scnt_d  = scnt_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        ready_d = 1'b0;
        err_d   = 1'b0;
        if (samp_clk) begin
            if (reset) begin
                state_d = StIdle;
                scnt_d  = '0;
                bit_d   = '0;
                shreg_d = '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (in) begin
                            state_d = StStart;
                            scnt_d  = '0;
                        end
                    end
                    StStart: begin
                        if (scnt_q == HALF_M1) begin
                            scnt_d  = '0;
                            bit_d   = '0;
                            state_d = in ? StData : StIdle;
                        end else begin
                            scnt_d = scnt_q + 1'b1;
                        end
                    end
                    StData: begin
                        if (scnt_q == LAST) begin
                            scnt_d         = '0;
                            shreg_d[bit_q] = ~in;
                            if (bit_q == BW'(DATA_BITS - 1)) state_d = StStop;
                            else bit_d = bit_q + 1'b1;
                        end else begin
                            scnt_d = scnt_q + 1'b1;
                        end
                    end
                    StStop: begin
                        if (scnt_q == LAST) begin
                            scnt_d  = '0;
                            ready_d = ~in;
                            state_d = in ? StBreak : StIdle;
                        end else begin
                            scnt_d = scnt_q + 1'b1;
                        end
                    end
                    // Bad stop bit: report once the line returns to idle, stay busy meanwhile.
                    StBreak: begin
                        if (!in) begin
                            err_d   = 1'b1;
                            state_d = StIdle;
                        end
                    end
                    default: state_d = StIdle;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        state_q <= state_d;
        scnt_q  <= scnt_d;
        bit_q   <= bit_d;
        shreg_q <= shreg_d;
        ready   <= ready_d;
        err     <= err_d;
    end

    assign out  = shreg_q;
    assign busy = (state_q != StIdle);

endmodule

// File: rtl/uart_rx_ctrl.sv
// Receive-side wrapper: strobe generation, receiver reset/watchdog, byte FIFO and status.
module uart_rx_ctrl
    import uart_rx_ctrl_pkg::*;
#(
    parameter int unsigned OVERSAMPLE   = 3,
    parameter int unsigned DEPTH_LOG2   = 2,
    parameter int unsigned WDOG_STROBES = WDOG_DEFAULT
) (
    input  logic        ref_clk,
    input  logic        reset,
    input  logic        rx_in,
    input  logic        enable,
    input  logic [15:0] divisor,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        overflow,
    output logic [7:0]  err_count,
    input  logic        err_clear,
    output logic        rx_busy
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned WW    = $clog2(WDOG_STROBES) + 1;

    logic                 samp_clk, rx_strobe, rx_rst, rx_ready, rx_err;
    logic [0:DATA_BITS-1] rx_out;
    logic [7:0]           rx_byte;
    logic [WW-1:0]        wcnt_q;
    logic                 wdog_q, wdog_trip, err_event;
    logic [7:0]           mem_q [DEPTH];
    logic [DEPTH_LOG2:0]  wr_ptr_q, rd_ptr_q;
    logic                 full, pop, push_ok, drop;

    uart_baud_strobe u_strobe (
        .clk      (ref_clk),
        .reset    (reset),
        .enable   (enable),
        .divisor  (divisor),
        .samp_clk (samp_clk)
    );

    assign rx_rst    = reset | ~enable | wdog_q;
    // The receiver only honours reset on strobes, so force one while the block is in reset.
    assign rx_strobe = samp_clk | reset;

    uart_rx #(
        .OVERSAMPLE (OVERSAMPLE)
    ) u_rx (
        .clk      (ref_clk),
        .reset    (rx_rst),
        .samp_clk (rx_strobe),
        .in       (rx_in),
        .out      (rx_out),
        .ready    (rx_ready),
        .err      (rx_err),
        .busy     (rx_busy)
    );

    always_comb begin
        rx_byte = '0;
        for (int i = 0; i < 8; i++) rx_byte[i] = rx_out[i];
    end

    assign wdog_trip = samp_clk && rx_busy && !rx_rst && (wcnt_q == WW'(WDOG_STROBES - 1));
    assign err_event = rx_err | wdog_trip;

    assign full    = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) &&
                     (wr_ptr_q[DEPTH_LOG2-1:0] == rd_ptr_q[DEPTH_LOG2-1:0]);
    assign m_valid = (wr_ptr_q != rd_ptr_q);
    assign m_data  = mem_q[rd_ptr_q[DEPTH_LOG2-1:0]];
    assign pop     = m_valid && m_ready;
    assign push_ok = rx_ready && (!full || pop);
    assign drop    = rx_ready && full && !pop;

    always_ff @(posedge ref_clk) begin
        if (reset) begin
            wcnt_q    <= '0;
            wdog_q    <= 1'b0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            overflow  <= 1'b0;
            err_count <= 8'd0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'd0;
        end else begin
            if (samp_clk) wdog_q <= wdog_trip;
            if (!rx_busy || rx_rst) wcnt_q <= '0;
            else if (samp_clk) wcnt_q <= wcnt_q + 1'b1;

            if (push_ok) begin
                mem_q[wr_ptr_q[DEPTH_LOG2-1:0]] <= rx_byte;
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;

            if (err_clear) begin
                overflow  <= drop;
                err_count <= {7'd0, err_event};
            end else begin
                if (drop) overflow <= 1'b1;
                if (err_event && err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
        end
    end

endmodule
